// File: rtl/lut_writer_pkg.sv
// Shared definitions for the look-up table load/read path: state encoding,
// byte width and the bytes-per-entry derivation.
package lut_writer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int bytes_per_entry(input int w);
    return (w + BYTE_W - 1) / BYTE_W;
  endfunction

  // Counter width that stays legal when an entry is a single byte
  function automatic int cnt_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/lut_word_assembler.sv
// Collects NB stream bytes LSB-first into one W-bit table entry and
// presents the completed entry as a held, registered word.
module lut_word_assembler
  import lut_writer_pkg::*;
#(
  parameter int W  = 8,
  parameter int NB = bytes_per_entry(W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_in,
  output logic [W-1:0]        word_out,
  output logic                last_byte
);

  localparam int CW = cnt_width(NB);

  logic [CW-1:0] byte_cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  word_next;

  // Each entry bit takes the incoming byte only when it belongs to the
  // byte slot being filled; bits of the last byte beyond W simply have no home.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign word_next[i] = (byte_cnt == CW'(i / BYTE_W)) ? byte_in[i % BYTE_W] : acc[i];
  end

  assign last_byte = (byte_cnt == CW'(NB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      acc      <= '0;
      word_out <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      acc      <= '0;
    end else if (byte_valid) begin
      acc <= word_next;
      if (last_byte) begin
        byte_cnt <= '0;
        word_out <= word_next;
      end else begin
        byte_cnt <= byte_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lut_writer.sv
// Writer side of the look-up table: streams bytes into entries and issues
// one write per entry at addresses 0..L-1, reporting busy/done/err.
module lut_writer
  import lut_writer_pkg::*;
#(
  parameter int L  = 256,
  parameter int W  = 8,
  parameter int AW = $clog2(L),
  parameter int NB = bytes_per_entry(W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [W-1:0]      wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, state_next;

  logic handshake;
  logic accept_start;
  logic abort_hit;
  logic last_byte;
  logic at_last;

  assign accept_start = (state == ST_IDLE) && start;
  assign abort_hit    = abort && ((state == ST_LOAD) || (state == ST_WRITE));
  assign handshake    = in_valid && in_ready;
  assign at_last      = (wr_addr == AW'(L - 1));

  lut_word_assembler #(
    .W  (W),
    .NB (NB)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_start || abort_hit),
    .byte_valid (handshake && !abort),
    .byte_in    (in_data),
    .word_out   (wr_data),
    .last_byte  (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (abort)                       state_next = ST_IDLE;
        else if (handshake && last_byte) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)        state_next = ST_IDLE;
        else if (at_last) state_next = ST_DONE;
        else              state_next = ST_LOAD;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Abort suppresses the write strobe in the very cycle it arrives
  always_comb begin
    in_ready = (state == ST_LOAD);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    wr_en    = (state == ST_WRITE) && !abort;
  end

  // Address holds at L-1 after the final write so it never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      err     <= 1'b0;
    end else if (accept_start) begin
      wr_addr <= '0;
      err     <= 1'b0;
    end else if (abort_hit) begin
      err <= 1'b1;
    end else if ((state == ST_WRITE) && !at_last) begin
      wr_addr <= wr_addr + AW'(1);
    end
  end

endmodule

// File: doc/lut_writer.md
Name: lut_writer

Overview:
- Loads a RAM-based look-up table from an 8-bit byte stream, the writer side of the table read path.
- Assembles NB = ceil(W/8) bytes per entry, least-significant byte first.
- Issues one single-cycle write per entry at sequential addresses 0..L-1.
- Reports busy, done and error status to the host controller that drives table reloads.

Parameters:
- L, 256: table length in entries.
- W, 8: entry width in bits.
- AW, $clog2(L): address width (derived; do not override).
- NB, (W+7)/8: bytes per entry (derived; do not override).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a full-table load; honoured only in IDLE.
- abort  input  1  cancels a load in progress.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a byte this cycle.
- wr_en  output  1  table write strobe, one cycle per entry.
- wr_addr  output  AW  table write address.
- wr_data  output  W  table write data.
- busy  output  1  high from start acceptance until DONE or abort.
- done  output  1  one-cycle pulse after entry L-1 is written.
- err  output  1  sticky abort flag; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; byte counter 0; assembly register 0.
- Byte handshake: a byte transfers when in_valid && in_ready on a rising clk edge.
- States:
  - IDLE: in_ready=0, busy=0. On start: go to LOAD, wr_addr<=0, byte_cnt<=0, assembly reg<=0, err<=0, busy<=1.
  - LOAD: in_ready=1.
    - On each handshake, write in_data into assembly bits [8*byte_cnt +: 8], truncated to W bits. For W not a multiple of 8, excess bits of the last byte are discarded.
    - If byte_cnt < NB-1, increment byte_cnt.
    - If byte_cnt == NB-1, go to WRITE and clear byte_cnt.
  - WRITE: in_ready=0; wr_en=1 for exactly this cycle; wr_data = assembled word; wr_addr = current address.
    - If wr_addr == L-1, go to DONE.
    - Otherwise increment wr_addr and return to LOAD.
  - DONE: done=1 for one cycle; busy<=0; go to IDLE. wr_addr holds L-1 until the next start.
- Latency: wr_en is asserted the cycle after the handshake of the last byte of an entry.
- Throughput: NB+1 cycles per entry with in_valid held high.
- Full load with in_valid held high takes L*(NB+1)+1 cycles from the start cycle to the done pulse.
- Address never wraps; no write is issued past L-1.
- wr_data is registered and holds its last value when wr_en=0.
- Abort:
  - In LOAD or WRITE, abort has priority over a simultaneous handshake or write. No wr_en is issued that cycle.
  - Next state is IDLE; busy<=0; err<=1; the partial assembly is discarded.
  - Abort in IDLE or DONE is ignored: DONE still completes and err stays 0.
- start while busy is ignored. start and abort together in IDLE: start wins and err stays 0.
- in_valid while in_ready=0 is ignored; the byte is not consumed.
- Asynchronous reset mid-load: immediate return to reset values; table contents already written are untouched (the RAM is external).

Decomposition:
- Shared package: state encoding (IDLE, LOAD, WRITE, DONE), the NB derivation, and a byte-width constant of 8. The table-read side uses the same L/W/AW conventions.
- One natural sub-module: lut_word_assembler. It holds byte_cnt and the assembly register, and exposes byte_in, byte_valid, clear, word_out and last_byte.
- The FSM, address counter and status flags stay in lut_writer.

Test Plan:
- L=4, W=8: start, stream bytes 0x11,0x22,0x33,0x44 with in_valid held high -> wr_en at addresses 0..3 with data 0x11..0x44, each write one cycle after its byte; done pulses once; busy then falls; err=0.
- L=4, W=12 (NB=2): bytes 0xBC,0xFA,0x34,0x12,... -> entry 0 = 0xABC, entry 1 = 0x234; upper nibble of every high byte discarded.
- L=4, W=8 with in_valid toggling every other cycle -> same writes and data as the first scenario, only stretched in time; no byte lost or duplicated; in_ready=0 during each WRITE cycle.
- Abort after entry 1 is written, asserted in the same cycle as a valid byte -> no further wr_en; busy=0 next cycle; err=1; a new start clears err and restarts at address 0.
- start pulsed again mid-load, and start pulsed in IDLE with no in_valid -> mid-load start has no effect; the IDLE start gives busy=1, in_ready=1, no wr_en until bytes arrive.
- Asynchronous reset asserted mid-LOAD between clock edges -> all outputs 0 immediately, without waiting for a clock edge; a subsequent start loads from address 0 correctly.
